// File: rtl/nano_pkg.sv
// nano_pkg: shared definitions for the NanoProcessor control unit.
//   - Field widths of the 9-bit instruction word {opcode, Rx, Ry}.
//   - Time-step state encoding T0..T3.
//   - Opcode constants for mv, mvi, add and sub.
package nano_pkg;

  localparam int OPCODE_W  = 3;
  localparam int REG_SEL_W = 3;
  localparam int INSTR_W   = OPCODE_W + 2 * REG_SEL_W;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_MV  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_MVI = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b011;

endpackage

// File: rtl/nano_control_unit.sv
// nano_control_unit: instruction sequencer for the NanoProcessor datapath.
// Latches an instruction from din in T0 when run is high, then steps it
// through T1..T3 and emits the datapath strobes plus the select/enable pairs
// for the downstream register-write and register-read 3-to-8 decoders.
//
// Ports:
//   clock   - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   run     - start-instruction request, sampled in T0 only
//   din     - data-in bus; instruction word in T0, immediate in mvi T1
//   wr_sel  - register-write select (0 when wr_en = 0)
//   wr_en   - write-decoder enable
//   rd_sel  - register-read select (0 when rd_en = 0)
//   rd_en   - read-decoder enable
//   ir_in   - instruction register load strobe
//   din_out - din drives the bus
//   a_in    - load accumulator A
//   g_in    - load result register G
//   g_out   - G drives the bus
//   add_sub - ALU op select, 0 = add, 1 = subtract
//   done    - instruction completes this cycle
module nano_control_unit
  import nano_pkg::*;
#(
  parameter int OPCODE_WIDTH  = OPCODE_W,
  parameter int REG_SEL_WIDTH = REG_SEL_W,
  parameter int INSTR_WIDTH   = OPCODE_WIDTH + 2 * REG_SEL_WIDTH
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     run,
  input  logic [INSTR_WIDTH-1:0]   din,
  output logic [REG_SEL_WIDTH-1:0] wr_sel,
  output logic                     wr_en,
  output logic [REG_SEL_WIDTH-1:0] rd_sel,
  output logic                     rd_en,
  output logic                     ir_in,
  output logic                     din_out,
  output logic                     a_in,
  output logic                     g_in,
  output logic                     g_out,
  output logic                     add_sub,
  output logic                     done
);

  state_t                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [REG_SEL_WIDTH-1:0] rx;
  logic [REG_SEL_WIDTH-1:0] ry;

  assign opcode = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign rx     = ir_q[2*REG_SEL_WIDTH-1 -: REG_SEL_WIDTH];
  assign ry     = ir_q[REG_SEL_WIDTH-1:0];

  // Decode: outputs depend only on the registered state, registered IR and
  // run, so every strobe is valid in the cycle its time step is entered.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wr_sel  = '0;
    wr_en   = 1'b0;
    rd_sel  = '0;
    rd_en   = 1'b0;
    ir_in   = 1'b0;
    din_out = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    add_sub = 1'b0;
    done    = 1'b0;

    case (state_q)
      T0: begin
        // Gated by resetn so a high run cannot raise ir_in while reset is held.
        if (run && resetn) begin
          ir_in   = 1'b1;
          ir_d    = din;
          state_d = T1;
        end
      end

      T1: begin
        state_d = T0;
        case (opcode)
          OP_MV: begin
            rd_sel = ry;
            rd_en  = 1'b1;
            wr_sel = rx;
            wr_en  = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            wr_sel  = rx;
            wr_en   = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rd_sel  = rx;
            rd_en   = 1'b1;
            a_in    = 1'b1;
            state_d = T2;
          end
          // Reserved opcodes retire as a one-step NOP.
          default: done = 1'b1;
        endcase
      end

      // T2/T3 are only reachable from add/sub.
      T2: begin
        rd_sel  = ry;
        rd_en   = 1'b1;
        g_in    = 1'b1;
        add_sub = (opcode == OP_SUB);
        state_d = T3;
      end

      T3: begin
        g_out   = 1'b1;
        wr_sel  = rx;
        wr_en   = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end

      default: state_d = T0;
    endcase
  end

  // State and IR registers; reset aborts any in-flight instruction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule
